// File: rtl/io_timer_irq.sv
// io_timer_irq: write-only memory-mapped prescaled 32-bit timer with compare match
// and a level interrupt for the core's interrupt_0 input.
module io_timer_irq #(
    parameter logic [9:0] BASE_ADR = 10'h3F0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  st_adr_io,
    input  logic [31:0] st_data_io,
    input  logic [3:0]  st_we_io,
    output logic        interrupt_0,
    output logic        timer_hit,
    output logic [31:0] count_out
);
    logic [2:0]  ctrl_q, ctrl_d;
    logic [15:0] presc_q, presc_d, pcnt_q, pcnt_d;
    logic [31:0] cmp_q, cmp_d, cnt_q, cnt_d;
    logic        pend_q, pend_d, hit_q, hit_d;
    logic [9:0]  off;
    logic [4:0]  sel;
    logic        tick, match, iclr, en_rise;

    function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n,
                                           input logic [3:0] be);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) r[8*k +: 8] = be[k] ? n[8*k +: 8] : o[8*k +: 8];
        return r;
    endfunction

    always_comb begin
        off = st_adr_io - BASE_ADR;
        sel = '0;
        if (|st_we_io && off < 10'd5) sel[off[2:0]] = 1'b1;
        en_rise = sel[0] && st_we_io[0] && st_data_io[0] && !ctrl_q[0];
        iclr = sel[3] && st_we_io[0] && st_data_io[0];
        tick = ctrl_q[0] && pcnt_q == presc_q;
        // A CNT store overrides the tick, so no match is evaluated on that cycle.
        match = tick && !sel[4] && cnt_q == cmp_q;
        ctrl_d = sel[0] && st_we_io[0] ? st_data_io[2:0] : ctrl_q;
        presc_d[7:0] = sel[1] && st_we_io[0] ? st_data_io[7:0] : presc_q[7:0];
        presc_d[15:8] = sel[1] && st_we_io[1] ? st_data_io[15:8] : presc_q[15:8];
        cmp_d = sel[2] ? bmerge(cmp_q, st_data_io, st_we_io) : cmp_q;
        pcnt_d = !ctrl_q[0] ? (en_rise ? 16'd0 : pcnt_q) : (tick ? 16'd0 : pcnt_q + 16'd1);
        cnt_d = sel[4] ? bmerge(cnt_q, st_data_io, st_we_io) :
                tick ? (match && ctrl_q[1] ? 32'd0 : cnt_q + 32'd1) : cnt_q;
        pend_d = match || (pend_q && !iclr);
        hit_d = match;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q  <= '0;
            presc_q <= '0;
            cmp_q   <= 32'hFFFF_FFFF;
            cnt_q   <= '0;
            pcnt_q  <= '0;
            pend_q  <= 1'b0;
            hit_q   <= 1'b0;
        end else begin
            ctrl_q  <= ctrl_d;
            presc_q <= presc_d;
            cmp_q   <= cmp_d;
            cnt_q   <= cnt_d;
            pcnt_q  <= pcnt_d;
            pend_q  <= pend_d;
            hit_q   <= hit_d;
        end
    end

    assign interrupt_0 = pend_q & ctrl_q[2];
    assign timer_hit   = hit_q;
    assign count_out   = cnt_q;
endmodule
